// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, word-addressed instruction memory
// and the IF/ID pipeline register with stall, flush and redirect control.
module fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misaligned_o
);

  localparam int unsigned AW       = $clog2(IMEM_DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Contents are preloaded externally; the design only reads it.
  logic [31:0] instr_memory [0:IMEM_DEPTH-1];

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_word;
  logic        out_of_range;

  assign pc_o     = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  // Addresses beyond the memory fetch a NOP rather than aliasing.
  assign out_of_range = |pc_q[31:AW+2];

  always_comb begin
    fetch_word = NOP_INSTR;
    if (!out_of_range) begin
      fetch_word = instr_memory[pc_q[AW+1:2]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      if_id_instr  <= NOP_INSTR;
      if_id_pc     <= '0;
      if_id_pc4    <= '0;
      if_id_valid  <= 1'b0;
      misaligned_o <= 1'b0;
    end else if (redirect_i) begin
      // Redirect squashes the wrong-path fetch regardless of stall/flush.
      pc_q         <= {redirect_pc_i[31:2], 2'b00};
      if_id_instr  <= NOP_INSTR;
      if_id_pc     <= '0;
      if_id_pc4    <= '0;
      if_id_valid  <= 1'b0;
      misaligned_o <= |redirect_pc_i[1:0];
    end else begin
      misaligned_o <= 1'b0;
      if (flush_i) begin
        if_id_instr <= NOP_INSTR;
        if_id_pc    <= '0;
        if_id_pc4   <= '0;
        if_id_valid <= 1'b0;
        if (!stall_i) begin
          pc_q <= pc_plus4;
        end
      end else if (!stall_i) begin
        if_id_instr <= fetch_word;
        if_id_pc    <= pc_q;
        if_id_pc4   <= pc_plus4;
        if_id_valid <= 1'b1;
        pc_q        <= pc_plus4;
      end
    end
  end

endmodule
